// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the serial comparator operand serializer.
package serial_cmp_pkg;

    localparam int unsigned DEFAULT_W = 16;

    typedef enum logic [0:0] {
        st_idle  = 1'b0,
        st_shift = 1'b1
    } ser_state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// W-bit parallel-in / serial-out register, MSB first, zero fill on shift.
module piso_shift_reg
    import serial_cmp_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sreg_q;
    logic [W-1:0] sreg_d;

    // Load has priority over shift; the serializer never requests both.
    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift) begin
            sreg_d = sreg_q << 1;
        end else begin
            sreg_d = sreg_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign msb = sreg_q[W-1];

endmodule

// File: rtl/serial_comparator_operand_serializer.sv
// Serializes parallel operand pairs MSB-first for the serial comparator,
// with first/last framing and a per-word comparator restart.
module serial_comparator_operand_serializer
    import serial_cmp_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    output logic         a,
    output logic         b,
    output logic         first,
    output logic         last,
    output logic         cmp_rst
);

    localparam int unsigned   CW      = cnt_width(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    ser_state_e    state_q;
    ser_state_e    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic busy_s;
    logic at_lsb_s;
    logic last_s;
    logic transfer_s;
    logic msb_a_s;
    logic msb_b_s;

    assign busy_s     = (state_q == st_shift);
    assign at_lsb_s   = (cnt_q == '0);
    assign last_s     = busy_s && at_lsb_s;
    assign in_ready   = !rst && (!busy_s || at_lsb_s);
    assign transfer_s = in_valid && in_ready;

    // Next state and bit counter; a reload on the LSB cycle keeps words back-to-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            st_idle: begin
                if (transfer_s) begin
                    state_d = st_shift;
                    cnt_d   = CNT_TOP;
                end else begin
                    state_d = st_idle;
                end
            end
            st_shift: begin
                if (!at_lsb_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (transfer_s) begin
                    cnt_d = CNT_TOP;
                end else begin
                    state_d = st_idle;
                end
            end
            default: begin
                state_d = st_idle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= st_idle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shift_reg #(.W(W)) u_sreg_a (
        .clk   (clk),
        .rst   (rst),
        .load  (transfer_s),
        .shift (busy_s && !at_lsb_s),
        .din   (in_a),
        .msb   (msb_a_s)
    );

    piso_shift_reg #(.W(W)) u_sreg_b (
        .clk   (clk),
        .rst   (rst),
        .load  (transfer_s),
        .shift (busy_s && !at_lsb_s),
        .din   (in_b),
        .msb   (msb_b_s)
    );

    // Data is gated while idle since the registers keep the LSB after a word ends.
    assign out_valid = busy_s;
    assign a         = busy_s && msb_a_s;
    assign b         = busy_s && msb_b_s;
    assign first     = busy_s && (cnt_q == CNT_TOP);
    assign last      = last_s;
    assign cmp_rst   = rst || !busy_s || last_s;

endmodule

// File: tb/tb_serial_comparator_operand_serializer.sv
// Self-checking bench: W=16 and W=1 serializers driven together, each feeding
// a serial comparator, checked against a word-level reference model.
module tb_serial_comparator_operand_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;

    logic [1:0] rdy, ov, oa, ob, fst, lst, crst;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_comparator_operand_serializer #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[0]), .a(oa[0]), .b(ob[0]),
        .first(fst[0]), .last(lst[0]), .cmp_rst(crst[0])
    );

    serial_comparator_operand_serializer #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a[0:0]), .in_b(in_b[0:0]), .out_valid(ov[1]), .a(oa[1]), .b(ob[1]),
        .first(fst[1]), .last(lst[1]), .cmp_rst(crst[1])
    );

    // Downstream MSB-first serial comparators, restarted by cmp_rst.
    logic gt_q [2];
    logic lt_q [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (crst[i]) begin
                gt_q[i] <= 1'b0;
                lt_q[i] <= 1'b0;
            end else if (!gt_q[i] && !lt_q[i]) begin
                gt_q[i] <= oa[i] & ~ob[i];
                lt_q[i] <= ~oa[i] & ob[i];
            end
        end
    end

    // Reference model: which word is in flight and which bit index is on the wire.
    int          wd [2] = '{16, 1};
    bit          m_busy [2];
    int          m_idx [2];
    logic [15:0] m_a [2];
    logic [15:0] m_b [2];
    bit          m_known = 1'b0;
    bit          acc [2];

    task automatic chk(input string tag, input int inst, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[W=%0d] @%0t: got %h expected %h", tag, wd[inst], $time, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [15:0] da, input logic [15:0] db);
        bit exp_rdy [2];
        bit e_last;
        logic vgt, vlt, veq;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_a     = da;
        in_b     = db;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_rdy[i] = !r && (!m_busy[i] || m_idx[i] == 0);
            e_last     = m_busy[i] && m_idx[i] == 0;
            if (m_known || r) begin
                chk("in_ready", i, rdy[i], exp_rdy[i]);
                chk("cmp_rst", i, crst[i], r || !m_busy[i] || e_last);
            end
            if (m_known) begin
                chk("out_valid", i, ov[i], m_busy[i]);
                chk("a", i, oa[i], m_busy[i] ? m_a[i][m_idx[i]] : 1'b0);
                chk("b", i, ob[i], m_busy[i] ? m_b[i][m_idx[i]] : 1'b0);
                chk("first", i, fst[i], m_busy[i] && m_idx[i] == wd[i] - 1);
                chk("last", i, lst[i], e_last);
                if (e_last) begin
                    vgt = gt_q[i] | (!gt_q[i] & !lt_q[i] & oa[i] & ~ob[i]);
                    vlt = lt_q[i] | (!gt_q[i] & !lt_q[i] & ~oa[i] & ob[i]);
                    veq = !gt_q[i] & !lt_q[i] & (oa[i] == ob[i]);
                    chk("a_greater_b", i, vgt, m_a[i] > m_b[i]);
                    chk("a_less_b", i, vlt, m_a[i] < m_b[i]);
                    chk("a_eq_b", i, veq, m_a[i] == m_b[i]);
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            acc[i] = 1'b0;
            if (r) begin
                m_busy[i] = 1'b0;
                m_idx[i]  = 0;
            end else if (m_busy[i] && m_idx[i] > 0) begin
                m_idx[i] = m_idx[i] - 1;
            end else if (v && exp_rdy[i]) begin
                acc[i]    = 1'b1;
                m_a[i]    = (wd[i] == 16) ? da : {15'd0, da[0]};
                m_b[i]    = (wd[i] == 16) ? db : {15'd0, db[0]};
                m_idx[i]  = wd[i] - 1;
                m_busy[i] = 1'b1;
            end else begin
                m_busy[i] = 1'b0;
            end
        end
        if (r) m_known = 1'b1;
    endtask

    task automatic send(input logic [15:0] da, input logic [15:0] db);
        bit done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            step(1'b0, 1'b1, da, db);
            done = acc[0];
        end
        if (!done) chk("send_timeout", 0, 16'd0, 16'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 16'h0000;
        in_b     = 16'h0000;
        step(1'b1, 1'b1, 16'hAAAA, 16'h5555);
        step(1'b1, 1'b1, 16'hAAAA, 16'h5555);
        idle(2);

        send(16'h6482, 16'h6262);
        idle(18);

        send(16'h0005, 16'h0003);
        send(16'h0001, 16'h8000);
        idle(18);

        send(16'h00F0, 16'h0F00);
        idle(18);
        send(16'hBEEF, 16'hBEEE);
        idle(18);

        send(16'hFFFF, 16'h0000);
        idle(4);
        step(1'b1, 1'b0, 16'h0000, 16'h0000);
        idle(1);
        send(16'h1234, 16'h1234);
        idle(18);

        send(16'h0001, 16'h0000);
        send(16'h0000, 16'h0001);
        idle(18);

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 16'($urandom), 16'($urandom));
        end
        idle(18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_comparator_operand_serializer.md
Name: serial_comparator_operand_serializer

Overview:
- Upstream feeder for the MSB-first serial comparator.
- Accepts operand pairs as parallel W-bit words through a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a/b.
- Drives a per-word comparator restart (cmp_rst) so consecutive words are compared independently, back-to-back, with no idle cycles.
- Exposes first/last framing so a downstream capture stage can sample the comparator verdict on the last bit.

Parameters:
- W, 16, operand width in bits; legal range W >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  serializer can accept a pair this cycle.
- in_a  input  W  operand A, parallel.
- in_b  input  W  operand B, parallel.
- out_valid  output  1  a/b carry a valid bit this cycle.
- a  output  1  current bit of A, MSB first.
- b  output  1  current bit of B, MSB first.
- first  output  1  current bit is the MSB of a word.
- last  output  1  current bit is the LSB of a word.
- cmp_rst  output  1  restart for the downstream comparator; wired to its rst.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high: rst.
- Handshake: a transfer occurs when in_valid && in_ready at a rising edge. in_a/in_b are sampled only on a transfer.
- in_ready = !rst && (!busy || last). A new pair is accepted during the LSB cycle of the current word, giving back-to-back operation.
- Latency: a transfer at edge t puts the MSBs on a/b in the cycle after t, with out_valid=1 and first=1.
- Word timing: out_valid stays high for exactly W consecutive cycles per word.
  - Bit index counts W-1 down to 0; a = sreg_a[W-1] and b = sreg_b[W-1].
  - Both registers shift left, zero-filled, each cycle.
- FSM states:
  - IDLE:
    - out_valid=0, a=0, b=0, first=0, last=0.
    - On a transfer, load sreg_a/sreg_b, set cnt=W-1, go to SHIFT.
  - SHIFT:
    - out_valid=1; first = (cnt==W-1); last = (cnt==0).
    - While cnt>0: shift, decrement cnt.
    - At cnt==0 with a transfer: reload and stay in SHIFT.
    - At cnt==0 without a transfer: go to IDLE.
- cmp_rst = rst || !busy || last (combinational).
  - It is high in the LSB cycle, so the comparator's state is equal in the next word's MSB cycle.
  - The comparator's combinational verdict on the LSB cycle is unaffected, because reset acts only at the edge.
- W=1: first and last are both high in the single bit cycle.
- Counter width: max(1, $clog2(W)).
- Reset, including mid-word:
  - State goes to IDLE; sreg_a, sreg_b and cnt clear to 0. Any word in flight is dropped.
  - From the first cycle after reset: out_valid=0, a=0, b=0, first=0, last=0.
  - While rst is high: in_ready=0 and cmp_rst=1.
- in_valid held low during SHIFT has no effect. A word, once started, always completes unless rst is asserted.

Decomposition:
- Package serial_cmp_pkg:
  - localparam default operand width (16).
  - enum logic [0:0] { st_idle, st_shift } serializer state typedef.
- One natural sub-module: piso_shift_reg, a W-bit parallel-in/serial-out MSB-first register with load and shift enables. Instantiate it twice, for A and B.
- FSM, counter and handshake logic live in the top module.

Test Plan:
- Reset: rst high 2 cycles with in_valid=1 -> in_ready=0, cmp_rst=1; after release, outputs idle (out_valid=0, a=b=0), in_ready=1.
- Single word, comparator attached: in_a=16'h6482, in_b=16'h6262 accepted at edge t.
  - Required: a bits 0110_0100_1000_0010 and b bits 0110_0010_0110_0010 on cycles t+1..t+16.
  - Required: first only at t+1, last only at t+16.
  - Required: comparator a_greater_b=1 at t+16.
- Back-to-back: in_valid held high with pairs (16'h0005, 16'h0003) then (16'h0001, 16'h8000).
  - Required: second word's MSB directly follows the first word's LSB.
  - Required: cmp_rst=1 on the first word's LSB cycle; comparator reports greater on word 1 and less on word 2.
- Gap: second pair presented 3 cycles after the first word ends -> out_valid=0 and cmp_rst=1 during the gap; second word starts 1 cycle after its transfer.
- Mid-word reset: rst asserted at bit 5 of 16'hFFFF vs 16'h0000.
  - Required: out_valid=0 the cycle after the reset edge.
  - Required: the next word, 16'h1234 vs 16'h1234, gives a_eq_b=1 at last.
- W=1 build: pairs (1,0) then (0,1) back-to-back -> first=last=1 each cycle; comparator greater then less.
